// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for an even-parity bit
module uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t         state, state_n;
   logic [CW-1:0]  clk_cnt, clk_cnt_n;
   logic [2:0]     bit_cnt, bit_cnt_n;
   logic [7:0]     shreg, shreg_n;
   logic           tx_q, tx_n;

   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic           push, pop, fifo_empty, clk_last;

   assign tx_ready   = (fifo_count != FULL_CNT);
   assign push       = tx_valid && tx_ready;
   assign fifo_empty = (fifo_count == '0);
   assign clk_last   = (clk_cnt == CLK_LAST);
   assign tx         = tx_q;
   assign tx_busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            fifo_count <= fifo_count + (AW+1)'(1);
         else if (pop && !push)
            fifo_count <= fifo_count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_n;
         clk_cnt <= clk_cnt_n;
         bit_cnt <= bit_cnt_n;
         shreg   <= shreg_n;
         tx_q    <= tx_n;
      end
   end

   always_comb begin
      state_n   = state;
      clk_cnt_n = clk_last ? '0 : clk_cnt + CW'(1);
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      tx_n      = tx_q;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            clk_cnt_n = '0;
            tx_n      = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_n = mem[rd_ptr];
               tx_n    = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (clk_last) begin
               bit_cnt_n = '0;
               tx_n      = shreg[0];
               state_n   = DATA;
            end
         end
         DATA: begin
            if (clk_last) begin
               if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_n    = ^shreg;
                  state_n = PARITY;
`else
                  tx_n    = 1'b1;
                  state_n = STOP;
`endif
               end else begin
                  bit_cnt_n = bit_cnt + 3'd1;
                  tx_n      = shreg[bit_cnt_n];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (clk_last) begin
               tx_n    = 1'b1;
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            if (clk_last) begin
               // Chain straight into the next start bit so queued frames have no idle gap.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shreg_n = mem[rd_ptr];
                  tx_n    = 1'b0;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            tx_n    = 1'b1;
            state_n = IDLE;
         end
      endcase
   end

endmodule
